// File: rtl/mem_ddr3_bridge_if.sv
// Request/response bus and MIG app_* signals for the PSX-to-DDR3 bridge.
// slave = bridge side, master = environment (CPU bus + MIG) side.
interface mem_ddr3_bridge_if #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 512
);
  logic                        req_valid;
  logic                        req_we;
  logic [31:0]                 req_addr;
  logic [31:0]                 req_wdata;
  logic [3:0]                  req_be;
  logic                        req_ready;
  logic                        rsp_valid;
  logic [31:0]                 rsp_rdata;
  logic                        init_calib_complete;
  logic [ADDR_WIDTH-1:0]       app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic                        app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_rd_data;
  logic                        app_rd_data_valid;
  logic                        app_rd_data_end;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, rsp_valid, rsp_rdata, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, init_calib_complete,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  req_ready, rsp_valid, rsp_rdata, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/mem_ddr3_bridge.sv
// Single-outstanding bridge: one 32-bit word access becomes one 512-bit BL8
// MIG command, byte-masked on writes and lane-selected on reads.
module mem_ddr3_bridge #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 512
) (
  input  logic                clk,
  input  logic                rst,
  mem_ddr3_bridge_if.slave    bus
);
  localparam int LANES  = APP_DATA_WIDTH / 32;
  localparam int MASK_W = APP_DATA_WIDTH / 8;
  localparam logic [2:0] CMD_WR  = 3'b000;
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [2:0] {CALIB, IDLE, WRITE, READ_CMD, READ_WAIT} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     app_addr_q, app_addr_d;
  logic [2:0]                app_cmd_q, app_cmd_d;
  logic                      app_en_q, app_en_d;
  logic [APP_DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
  logic [MASK_W-1:0]         wdf_mask_q, wdf_mask_d;
  logic                      wdf_wren_q, wdf_wren_d;
  logic                      wdf_end_q, wdf_end_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      cmd_done_q, cmd_done_d;
  logic                      dat_done_q, dat_done_d;
  logic [3:0]                word_q, word_d;

  logic [31:0]               rd_lane [LANES];
  logic [APP_DATA_WIDTH-1:0] wdata_rep;
  logic [MASK_W-1:0]         wmask_word;
  logic                      cmd_ok, dat_ok;
  logic                      unused_ok;

  // Per-lane read slicing, write replication and byte-mask for the addressed word.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_lane[gi]              = bus.app_rd_data[32*gi +: 32];
      assign wdata_rep[32*gi +: 32]   = bus.req_wdata;
      assign wmask_word[4*gi +: 4]    = (bus.req_addr[5:2] == 4'(gi)) ? ~bus.req_be : 4'hF;
    end
  endgenerate

  assign unused_ok = ^{bus.app_rd_data_end, bus.req_addr[1:0], bus.req_addr[31:ADDR_WIDTH+3]};

  assign cmd_ok = app_en_q & bus.app_rdy;
  assign dat_ok = wdf_wren_q & bus.app_wdf_rdy;

  always_comb begin
    state_d     = state_q;
    app_addr_d  = app_addr_q;
    app_cmd_d   = app_cmd_q;
    app_en_d    = app_en_q;
    wdf_data_d  = wdf_data_q;
    wdf_mask_d  = wdf_mask_q;
    wdf_wren_d  = wdf_wren_q;
    wdf_end_d   = wdf_end_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cmd_done_d  = cmd_done_q;
    dat_done_d  = dat_done_q;
    word_d      = word_q;

    case (state_q)
      CALIB: begin
        if (bus.init_calib_complete) state_d = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          app_addr_d = {bus.req_addr[ADDR_WIDTH+2:6], 3'b000};
          word_d     = bus.req_addr[5:2];
          app_en_d   = 1'b1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          if (bus.req_we) begin
            app_cmd_d  = CMD_WR;
            wdf_data_d = wdata_rep;
            wdf_mask_d = wmask_word;
            wdf_wren_d = 1'b1;
            wdf_end_d  = 1'b1;
            state_d    = WRITE;
          end else begin
            app_cmd_d  = CMD_RD;
            state_d    = READ_CMD;
          end
        end
      end
      WRITE: begin
        // Command and data handshakes finish independently, in either order.
        if (cmd_ok) begin
          app_en_d   = 1'b0;
          cmd_done_d = 1'b1;
        end
        if (dat_ok) begin
          wdf_wren_d = 1'b0;
          wdf_end_d  = 1'b0;
          dat_done_d = 1'b1;
        end
        if (cmd_done_d && dat_done_d) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      READ_CMD: begin
        if (cmd_ok) begin
          app_en_d = 1'b0;
          state_d  = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (bus.app_rd_data_valid) begin
          rsp_rdata_d = rd_lane[word_q];
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = CALIB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CALIB;
      app_addr_q  <= '0;
      app_cmd_q   <= CMD_NOP;
      app_en_q    <= 1'b0;
      wdf_data_q  <= '0;
      wdf_mask_q  <= '1;
      wdf_wren_q  <= 1'b0;
      wdf_end_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_done_q  <= 1'b0;
      dat_done_q  <= 1'b0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      app_addr_q  <= app_addr_d;
      app_cmd_q   <= app_cmd_d;
      app_en_q    <= app_en_d;
      wdf_data_q  <= wdf_data_d;
      wdf_mask_q  <= wdf_mask_d;
      wdf_wren_q  <= wdf_wren_d;
      wdf_end_q   <= wdf_end_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_done_q  <= cmd_done_d;
      dat_done_q  <= dat_done_d;
      word_q      <= word_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.app_addr     = app_addr_q;
  assign bus.app_cmd      = app_cmd_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_data = wdf_data_q;
  assign bus.app_wdf_mask = wdf_mask_q;
  assign bus.app_wdf_wren = wdf_wren_q;
  assign bus.app_wdf_end  = wdf_end_q;
endmodule

// File: tb/tb_mem_ddr3_bridge.sv
// Scoreboard bench for mem_ddr3_bridge: expected read words are queued at
// request acceptance and compared when rsp_valid pulses.
module tb_mem_ddr3_bridge;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   rsp_cnt;
  int   last_rsp_cyc;
  logic [31:0] exp_q [$];

  mem_ddr3_bridge_if #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(512)) bus ();

  mem_ddr3_bridge #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", bus.rsp_valid, 1'b0);
      end else begin
        check_eq("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      end
      $display("rsp cyc=%0d rdata=%08h", cyc, bus.rsp_rdata);
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, output int n);
    int t;
    n = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.req_ready === 1'b1) begin
      n = cyc;
      exp_q.push_back(exp_rd);
      $display("req cyc=%0d we=%0b addr=%08h wdata=%08h be=%04b", n, we, addr, wdata, be);
    end else begin
      check_eq("accept_timeout", bus.req_ready, 1'b1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, r0, viol, en_cnt, wr_cnt;
    n_checks = 0; n_fail = 0; rsp_cnt = 0; last_rsp_cyc = -1;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;   bus.init_calib_complete = 1'b0;
    bus.app_rdy = 1'b1;   bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_app_en", bus.app_en, 1'b0);
    check_eq("rst_app_cmd", bus.app_cmd, 3'b111);
    check_eq("rst_mask", bus.app_wdf_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("rst_wren", bus.app_wdf_wren, 1'b0);
    check_eq("rst_req_ready", bus.req_ready, 1'b0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;

    // Calibration gating with a masked write pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h48;
    bus.req_wdata = 32'hDEADBEEF; bus.req_be = 4'b0101;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0 || bus.app_en !== 1'b0) viol++;
    end
    check_eq("calib_gate", viol, 0);
    c = cyc;
    bus.init_calib_complete = 1'b1;
    r0 = rsp_cnt;
    do_req(1'b1, 32'h48, 32'hDEADBEEF, 4'b0101, 32'h0, n);
    check_eq("calib_accept", (n >= 0 && n - c <= 2), 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("mw_app_en", bus.app_en, 1'b1);
    check_eq("mw_wren", bus.app_wdf_wren, 1'b1);
    check_eq("mw_wdf_end", bus.app_wdf_end, 1'b1);
    check_eq("mw_cmd", bus.app_cmd, 3'b000);
    check_eq("mw_addr", bus.app_addr, 28'h0000008);
    check_eq("mw_mask", bus.app_wdf_mask, 64'hFFFF_FFFF_FFFF_FAFF);
    check_eq("mw_data", bus.app_wdf_data, {16{32'hDEADBEEF}});
    @(negedge clk);
    check_eq("mw_ready_n2", bus.req_ready, 1'b1);
    check_eq("mw_en_drop", bus.app_en, 1'b0);
    check_eq("mw_wren_drop", bus.app_wdf_wren, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("mw_rsp_cyc", last_rsp_cyc, n + 2);
    check_eq("mw_rsp_cnt", rsp_cnt - r0, 1);

    // Write with no byte enables still completes with a full mask.
    r0 = rsp_cnt;
    do_req(1'b1, 32'h7C, 32'h12345678, 4'b0000, 32'h0, n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("be0_mask", bus.app_wdf_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    check_eq("be0_rsp_cyc", last_rsp_cyc, n + 2);
    check_eq("be0_rsp_cnt", rsp_cnt - r0, 1);

    // Split write handshake: data side stalls for 5 cycles.
    bus.app_wdf_rdy = 1'b0;
    r0 = rsp_cnt; en_cnt = 0; wr_cnt = 0;
    do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'b1111, 32'h0, n);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.req_valid = 1'b0;
        check_eq("sw_mask", bus.app_wdf_mask, 64'hFFFF_FFFF_FFF0_FFFF);
      end
      if (bus.app_en === 1'b1) en_cnt++;
      if (bus.app_wdf_wren === 1'b1) wr_cnt++;
      if (i == 6) bus.app_wdf_rdy = 1'b1;
    end
    check_eq("sw_en_cycles", en_cnt, 1);
    check_eq("sw_wren_cycles", wr_cnt, 6);
    check_eq("sw_rsp_cyc", last_rsp_cyc, n + 7);
    check_eq("sw_rsp_cnt", rsp_cnt - r0, 1);

    // Read lane select: word 7, data 10 cycles after command accept.
    for (int k = 0; k < 16; k++) bus.app_rd_data[32*k +: 32] = 32'(k);
    r0 = rsp_cnt; en_cnt = 0;
    do_req(1'b0, 32'h1C, 32'h0, 4'b0000, 32'd7, n);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.req_valid = 1'b0;
        check_eq("rd_cmd", bus.app_cmd, 3'b001);
        check_eq("rd_addr", bus.app_addr, 28'h0);
      end
      if (bus.app_en === 1'b1) en_cnt++;
      if (i == 11) bus.app_rd_data_valid = 1'b1;
      if (i == 12) bus.app_rd_data_valid = 1'b0;
    end
    check_eq("rd_en_cycles", en_cnt, 1);
    check_eq("rd_rsp_cyc", last_rsp_cyc, n + 12);
    check_eq("rd_rsp_cnt", rsp_cnt - r0, 1);

    // Read with app_rdy held off for 3 cycles.
    for (int k = 0; k < 16; k++) bus.app_rd_data[32*k +: 32] = 32'hA500_0000 + 32'(k);
    bus.app_rdy = 1'b0;
    r0 = rsp_cnt; en_cnt = 0;
    do_req(1'b0, 32'h2004, 32'h0, 4'b0000, 32'hA500_0001, n);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
      if (i == 4) check_eq("rd2_addr_hold", bus.app_addr, 28'h0000400);
      if (bus.app_en === 1'b1) en_cnt++;
      if (i == 4) bus.app_rdy = 1'b1;
      if (i == 6) bus.app_rd_data_valid = 1'b1;
      if (i == 7) bus.app_rd_data_valid = 1'b0;
    end
    check_eq("rd2_en_cycles", en_cnt, 4);
    check_eq("rd2_rsp_cyc", last_rsp_cyc, n + 7);
    check_eq("rd2_rsp_cnt", rsp_cnt - r0, 1);

    // Stray read data while idle.
    r0 = rsp_cnt;
    @(negedge clk); bus.app_rd_data_valid = 1'b1;
    @(negedge clk); bus.app_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stray_idle", rsp_cnt - r0, 0);

    // Reset while waiting for read data.
    r0 = rsp_cnt;
    do_req(1'b0, 32'h3C, 32'h0, 4'b0000, 32'hA500_000F, n);
    @(negedge clk); bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check_eq("mid_rst_app_en", bus.app_en, 1'b0);
    check_eq("mid_rst_cmd", bus.app_cmd, 3'b111);
    check_eq("mid_rst_addr", bus.app_addr, 28'h0);
    check_eq("mid_rst_mask", bus.app_wdf_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("mid_rst_data", bus.app_wdf_data, 512'h0);
    check_eq("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    check_eq("mid_rst_ready", bus.req_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.app_rd_data_valid = 1'b1;
    @(negedge clk); bus.app_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_stray", rsp_cnt - r0, 0);
    check_eq("post_rst_ready", bus.req_ready, 1'b1);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_ddr3_bridge.md
# mem_ddr3_bridge

Single-outstanding request bridge between the PSX memory-side bus (32-bit word reads and writes with byte enables) and the MIG 7-series DDR3 user (app_*) interface. It sits directly upstream of the DDR3 controller. It converts each 32-bit access into one 512-bit BL8 line command, with byte masking on writes and lane selection on reads. It also holds off all requests until DDR3 calibration completes.

## Interface
- ADDR_WIDTH, 28: MIG app_addr width.
- APP_DATA_WIDTH, 512: MIG app data width (nCK_PER_CLK*2*64). This block supports only 512.
- clk  input  1: the single clock (MIG ui_clk domain); all logic is rising-edge.
- rst  input  1: reset, asynchronous and active-high.
- req_valid  input  1: request present.
- req_we  input  1: 1 = write, 0 = read.
- req_addr  input  32: byte address. Bits [1:0] are ignored.
- req_wdata  input  32: write word.
- req_be  input  4: byte enables. Bit i enables req_wdata[8i+7:8i].
- req_ready  output  1: bridge accepts the request this cycle.
- rsp_valid  output  1: one-cycle completion pulse, for both reads and writes.
- rsp_rdata  output  32: read word. It is 0 on write completion.
- init_calib_complete  input  1: from MIG.
- app_addr  output  ADDR_WIDTH; app_cmd  output  3; app_en  output  1; app_rdy  input  1.
- app_wdf_data  output  512; app_wdf_mask  output  64; app_wdf_wren  output  1; app_wdf_end  output  1; app_wdf_rdy  input  1.
- app_rd_data  input  512; app_rd_data_valid  input  1; app_rd_data_end  input  1 (unused, BL8 single beat).

## Operation
- States: CALIB, IDLE, WRITE, READ_CMD, READ_WAIT.
- Reset (async, from any state):
  - state = CALIB.
  - app_en, app_wdf_wren, app_wdf_end, rsp_valid = 0.
  - rsp_rdata, app_addr, app_wdf_data = 0.
  - app_cmd = 3'b111.
  - app_wdf_mask = all ones.
  - Any in-flight MIG transaction is abandoned.
- CALIB: req_ready = 0. Move to IDLE when init_calib_complete = 1. After that, init_calib_complete is not re-checked.
- IDLE: req_ready = 1 (combinational on state only). On req_valid, capture the request:
  - app_addr = {req_addr[ADDR_WIDTH+2:6], 3'b000}.
  - word index w = req_addr[5:2].
- Write path (IDLE -> WRITE):
  - app_cmd = 000.
  - app_wdf_data = req_wdata replicated 16×.
  - app_wdf_mask = all ones except bits [4w+3:4w] = ~req_be.
  - app_en = app_wdf_wren = app_wdf_end = 1.
- WRITE:
  - app_en drops the cycle after app_en & app_rdy; the cmd_done flag is set.
  - app_wdf_wren and app_wdf_end drop the cycle after app_wdf_wren & app_wdf_rdy; the dat_done flag is set.
  - The two handshakes are independent and may complete in either order or in the same cycle.
  - When both are done: go to IDLE, pulse rsp_valid, rsp_rdata = 0.
- Read path (IDLE -> READ_CMD): app_cmd = 001, app_en = 1.
- READ_CMD: on app_rdy, app_en drops next cycle and the state moves to READ_WAIT.
- READ_WAIT: on app_rd_data_valid, rsp_rdata <= app_rd_data[32w+31:32w], pulse rsp_valid, go to IDLE.
- app_rd_data_valid seen in any state other than READ_WAIT is ignored.
- req_be = 0 on a write is legal. The full mask is issued and completion is still signalled.
- Outputs hold their values while waiting. app_cmd and app_addr stay stable for as long as app_en = 1.

## Timing
- All outputs except req_ready are registered.
- Accept at cycle N (req_valid & req_ready). app_en and app_wdf_wren are high at N+1.
- Write, MIG ready throughout: both handshakes complete at N+1, rsp_valid at N+2, req_ready at N+2.
- Write, app_wdf_rdy low for k cycles: rsp_valid at N+2+k.
- Read: command accepted at cycle A ≥ N+1. If app_rd_data_valid arrives at cycle M > A, rsp_valid is at M+1.
- Throughput: at most one request in flight. The next accept is no earlier than the rsp_valid cycle.

## Test plan
- **Calibration gating:** hold init_calib_complete = 0 for 100 cycles with req_valid = 1 -> req_ready stays 0 and app_en stays 0. Raise calib -> accepted within 2 cycles.
- **Masked write:** addr 0x0000_0048, wdata 0xDEADBEEF, be 4'b0101 -> app_addr = 0x0000_0008, w = 2, app_wdf_mask = 64'hFFFF_FFFF_FFFF_FAFF, data = 0xDEADBEEF×16, rsp_valid at N+2 with the MIG always ready.
- **Split write handshake:** app_rdy high at once, app_wdf_rdy low 5 cycles -> app_en is a single cycle, wren is held 6 cycles, a single rsp_valid at N+7.
- **Read lane select:** addr 0x1C (w = 7), app_rd_data lanes = index values 0..15, valid 10 cycles after command accept -> rsp_rdata = 7, rsp_valid exactly one cycle.
- **Stray data and reset mid-read:** pulse app_rd_data_valid in IDLE -> no rsp_valid. Assert rst during READ_WAIT -> state CALIB, all outputs at reset values, and a later app_rd_data_valid produces no response.
